lpc_capture_ctrl: RTL and testbench
===================================

LPC_CAPTURE_CTRL -- requirements
Module: lpc_capture_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, record FIFO depth; SHALL be a power of two, minimum 4.
REQ-002 Parameter SYNC_BYTE, default 8'h5A, first byte of every serialized record.
REQ-003 lpc_clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 lpc_reset  in  1  asynchronous active-low reset.
REQ-005 capture_en  in  1  high = accept new records.
REQ-006 in_clock_enable  in  1  decoder "transaction complete" level; a record is captured on its 0->1 transition.
REQ-007 in_cyctype_dir  in  4  decoded cycle type/direction.
REQ-008 in_addr  in  16  decoded I/O address.
REQ-009 in_data  in  8  decoded data byte.
REQ-010 tx_data  out  8  serialized byte to the host link.
REQ-011 tx_valid  out  1  tx_data is valid.
REQ-012 tx_ready  in  1  sink accepts tx_data when tx_valid and tx_ready are both high at a rising edge.
REQ-013 fifo_level  out  log2(FIFO_DEPTH)+1  number of records stored.
REQ-014 overflow_count  out  8  dropped-record count, saturating.
REQ-015 busy  out  1  high while the serializer is not IDLE or fifo_level is nonzero.

Function
REQ-016 Capture edge: prev_ce SHALL register in_clock_enable each cycle; capture is detected when in_clock_enable=1 and prev_ce=0.
REQ-017 On capture with capture_en=1, the block SHALL push {in_cyctype_dir, in_addr, in_data} into the FIFO at that same edge.
REQ-018 Push with fifo_level==FIFO_DEPTH before the edge SHALL drop the record and increment overflow_count, which saturates at 255; a pop at the same edge does not free space for the push.
REQ-019 Capture with capture_en=0 SHALL be ignored, and overflow_count SHALL NOT change.
REQ-020 Serializer states: IDLE, SEND. The byte index runs 0..N-1, with N=5 (7 with the timestamp feature).
REQ-021 Byte order: SYNC_BYTE, {4'h0,cyctype_dir}, addr[15:8], addr[7:0], data.
REQ-022 IDLE with FIFO non-empty: the block SHALL pop at the next edge, load byte 0, assert tx_valid and enter SEND. First byte valid 2 edges after the capture edge.
REQ-023 In SEND, tx_data and tx_valid SHALL hold stable until accepted; tx_valid SHALL never drop without acceptance.
REQ-024 On acceptance of byte k<N-1, byte k+1 SHALL be presented after the same edge, giving 1 byte/cycle while tx_ready stays high.
REQ-025 On acceptance of byte N-1: if the FIFO is non-empty, the block SHALL pop and present byte 0 of the next record after the same edge (no gap); otherwise tx_valid=0 and the state returns to IDLE.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL reflect simultaneous push+pop as unchanged.
REQ-027 De-asserting capture_en SHALL NOT stop draining of stored records.

Reset
REQ-028 lpc_reset low SHALL immediately force tx_valid=0, tx_data=0, fifo_level=0, overflow_count=0, busy=0, state IDLE, pointers 0, and timestamp 0.
REQ-029 prev_ce SHALL reset to 1, so a decoder level left high across reset is not captured.
REQ-030 A reset mid-record SHALL discard the partial record; after release the next output SHALL start with SYNC_BYTE.

Configuration
REQ-031 Macro LPC_CAPTURE_TIMESTAMP_EN defined: a free-running 16-bit counter (wraps at 0xFFFF) is sampled at the capture edge, stored per record, and appended as ts[15:8], ts[7:0] after data, giving N=7.
REQ-032 Macro LPC_CAPTURE_TIMESTAMP_EN undefined: no counter and no timestamp storage exist, and N=5.

Verification
REQ-033 Single capture (cyctype 0, addr 0x0024, data 0xA5) with tx_ready=1 -> 5A 00 00 24 A5 on 5 consecutive cycles, first byte 2 edges after the capture edge, then tx_valid=0.
REQ-034 tx_ready toggled 1-0-1-0 during a record -> each byte is held while ready=0, no byte is lost or duplicated, and the order is unchanged.
REQ-035 tx_ready=0 with 18 captures at FIFO_DEPTH=16 -> fifo_level=16, overflow_count=2; after ready=1 exactly 16 records drain back-to-back with no gaps.
REQ-036 in_clock_enable held high for 10 cycles -> one record only. Reset asserted while it is high and then released -> no record.
REQ-037 Reset asserted at byte 3 of a record, then one new capture -> tx_valid drops asynchronously, and the next output begins 5A with the new record only.
REQ-038 With LPC_CAPTURE_TIMESTAMP_EN, captures 0x100 cycles apart after reset -> the timestamp fields differ by 0x0100. Without the macro, records are 5 bytes.

Source files
------------

// File: rtl/lpc_capture_ctrl.sv
// lpc_capture_ctrl
// Captures decoded LPC transactions into a record FIFO and serializes each
// record as a byte stream over a valid/ready link to the host.
//
// Record bytes, in order: SYNC_BYTE, {4'h0, cyctype_dir}, addr[15:8],
// addr[7:0], data. When LPC_CAPTURE_TIMESTAMP_EN is defined, a free-running
// 16-bit timestamp is sampled at capture and two more bytes follow:
// ts[15:8], ts[7:0].
//
// Parameters:
//   FIFO_DEPTH  record FIFO depth (power of two, >= 4)
//   SYNC_BYTE   leading byte of every serialized record
//
// Ports:
//   lpc_clock        single clock, rising edge
//   lpc_reset        asynchronous active-low reset
//   capture_en       accept new records when high
//   in_clock_enable  decoder "transaction complete" level; capture on 0->1
//   in_cyctype_dir   decoded cycle type / direction
//   in_addr          decoded I/O address
//   in_data          decoded data byte
//   tx_data          serialized byte
//   tx_valid         tx_data is valid
//   tx_ready         sink accepts when tx_valid && tx_ready at a rising edge
//   fifo_level       number of records stored
//   overflow_count   dropped-record count, saturating at 255
//   busy             serializer active or records pending
//
// Serializer states:
//   state   | meaning
//   --------+--------------------------------------------------------
//   ST_IDLE | nothing presented; pops a record as soon as one is stored
//   ST_SEND | presenting byte byte_idx of rec_q, held until accepted

module lpc_capture_ctrl #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  SYNC_BYTE  = 8'h5A
) (
  input  logic                         lpc_clock,
  input  logic                         lpc_reset,
  input  logic                         capture_en,
  input  logic                         in_clock_enable,
  input  logic [3:0]                   in_cyctype_dir,
  input  logic [15:0]                  in_addr,
  input  logic [7:0]                   in_data,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [7:0]                   overflow_count,
  output logic                         busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

`ifdef LPC_CAPTURE_TIMESTAMP_EN
  localparam int         REC_W    = 44;
  localparam logic [2:0] LAST_IDX = 3'd6;
`else
  localparam int         REC_W    = 28;
  localparam logic [2:0] LAST_IDX = 3'd4;
`endif

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t             state, state_nxt;
  logic [2:0]         byte_idx, byte_idx_nxt;
  logic [REC_W-1:0]   rec_q, rec_nxt;
  logic [7:0]         tx_data_nxt;
  logic               tx_valid_nxt;

  logic               prev_ce;
  logic               push_req;
  logic               push_ok;
  logic               pop;
  logic               full;
  logic               empty;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [REC_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [REC_W-1:0]   rec_in;
  logic [REC_W-1:0]   head;

  // ------------------------------------------------------------------
  // Capture edge detect. prev_ce resets high so a level that is already
  // high when reset releases is not taken as a new transaction.
  // ------------------------------------------------------------------
  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) prev_ce <= 1'b1;
    else            prev_ce <= in_clock_enable;
  end

  assign push_req = in_clock_enable && !prev_ce && capture_en;

`ifdef LPC_CAPTURE_TIMESTAMP_EN
  logic [15:0] ts_cnt;

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) ts_cnt <= 16'h0000;
    else            ts_cnt <= ts_cnt + 16'h0001;
  end

  assign rec_in = {ts_cnt, in_cyctype_dir, in_addr, in_data};
`else
  assign rec_in = {in_cyctype_dir, in_addr, in_data};
`endif

  // ------------------------------------------------------------------
  // Record FIFO. Fullness is judged on the level before the edge, so a
  // pop at the same edge never makes room for a push.
  // ------------------------------------------------------------------
  assign full    = (fifo_level == LW'(FIFO_DEPTH));
  assign empty   = (fifo_level == '0);
  assign push_ok = push_req && !full;
  assign head    = fifo_mem[rd_ptr];

  always_ff @(posedge lpc_clock) begin
    if (push_ok) fifo_mem[wr_ptr] <= rec_in;
  end

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      overflow_count <= 8'h00;
    end else if (push_req && full && (overflow_count != 8'hFF)) begin
      overflow_count <= overflow_count + 8'h01;
    end
  end

  // ------------------------------------------------------------------
  // Serializer
  // ------------------------------------------------------------------
  function automatic logic [7:0] rec_byte(input logic [REC_W-1:0] rec,
                                          input logic [2:0]       idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0:    b = SYNC_BYTE;
      3'd1:    b = {4'h0, rec[27:24]};
      3'd2:    b = rec[23:16];
      3'd3:    b = rec[15:8];
      3'd4:    b = rec[7:0];
`ifdef LPC_CAPTURE_TIMESTAMP_EN
      3'd5:    b = rec[43:36];
      3'd6:    b = rec[35:28];
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      state    <= ST_IDLE;
      byte_idx <= 3'd0;
      rec_q    <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      byte_idx <= byte_idx_nxt;
      rec_q    <= rec_nxt;
      tx_data  <= tx_data_nxt;
      tx_valid <= tx_valid_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    byte_idx_nxt = byte_idx;
    rec_nxt      = rec_q;
    tx_data_nxt  = tx_data;
    tx_valid_nxt = tx_valid;
    pop          = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop          = 1'b1;
          rec_nxt      = head;
          byte_idx_nxt = 3'd0;
          tx_data_nxt  = SYNC_BYTE;
          tx_valid_nxt = 1'b1;
          state_nxt    = ST_SEND;
        end
      end

      ST_SEND: begin
        if (tx_valid && tx_ready) begin
          if (byte_idx == LAST_IDX) begin
            // Chain straight into the next record when one is waiting so
            // back-to-back records leave no idle cycle on the link.
            if (!empty) begin
              pop          = 1'b1;
              rec_nxt      = head;
              byte_idx_nxt = 3'd0;
              tx_data_nxt  = SYNC_BYTE;
              tx_valid_nxt = 1'b1;
            end else begin
              byte_idx_nxt = 3'd0;
              tx_data_nxt  = 8'h00;
              tx_valid_nxt = 1'b0;
              state_nxt    = ST_IDLE;
            end
          end else begin
            byte_idx_nxt = byte_idx + 3'd1;
            tx_data_nxt  = rec_byte(rec_q, byte_idx + 3'd1);
          end
        end
      end

      default: begin
        state_nxt    = ST_IDLE;
        tx_valid_nxt = 1'b0;
        tx_data_nxt  = 8'h00;
        byte_idx_nxt = 3'd0;
      end
    endcase
  end

  assign busy = (state != ST_IDLE) || !empty;

endmodule

// File: tb/tb_lpc_capture_ctrl.sv
module tb_lpc_capture_ctrl;

  logic        lpc_clock;
  logic        lpc_reset;
  logic        capture_en;
  logic        in_clock_enable;
  logic [3:0]  in_cyctype_dir;
  logic [15:0] in_addr;
  logic [7:0]  in_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [4:0]  fifo_level;
  logic [7:0]  overflow_count;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  lpc_capture_ctrl dut (
    .lpc_clock       (lpc_clock),
    .lpc_reset       (lpc_reset),
    .capture_en      (capture_en),
    .in_clock_enable (in_clock_enable),
    .in_cyctype_dir  (in_cyctype_dir),
    .in_addr         (in_addr),
    .in_data         (in_data),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .fifo_level      (fifo_level),
    .overflow_count  (overflow_count),
    .busy            (busy)
  );

  initial lpc_clock = 1'b0;
  always #5 lpc_clock = ~lpc_clock;

  typedef struct {
    logic        ce;
    logic        en;
    logic        rdy;
    logic [3:0]  cyc;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic [4:0]  exp_level;
    logic [7:0]  exp_ovf;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Record r of the hand sequences: cyc=r[3:0], addr=0x1000+r, data=0x40+r
  function automatic logic [7:0] exp_byte(input int r, input int k);
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  rb;
    a  = 16'h1000 + 16'(r);
    d  = 8'h40 + 8'(r);
    rb = 8'(r);
    case (k)
      0:       return 8'h5A;
      1:       return {4'h0, rb[3:0]};
      2:       return a[15:8];
      3:       return a[7:0];
      default: return d;
    endcase
  endfunction

  task automatic set_rec(input int r);
    logic [7:0] rb;
    rb = 8'(r);
    in_cyctype_dir = rb[3:0];
    in_addr        = 16'h1000 + 16'(r);
    in_data        = 8'h40 + 8'(r);
  endtask

  task automatic cap(input int r);
    set_rec(r);
    in_clock_enable = 1'b1;
    @(negedge lpc_clock);
    in_clock_enable = 1'b0;
    @(negedge lpc_clock);
  endtask

  task automatic chk_record(input string tag, input int r);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s_r%0d_b%0d_valid", tag, r, k), tx_valid, 1'b1);
      chk($sformatf("%s_r%0d_b%0d_data", tag, r, k), tx_data, exp_byte(r, k));
      @(negedge lpc_clock);
    end
  endtask

  initial begin
    int cnt;

    //            ce    en    rdy   cyc   addr      data    v     d      lvl   ovf    busy
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 4'h0, 16'h0024, 8'hA5, 1'b0, 8'h00, 5'd0, 8'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 4'h0, 16'h0024, 8'hA5, 1'b0, 8'h00, 5'd1, 8'd0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 4'h0, 16'h0024, 8'hA5, 1'b1, 8'h5A, 5'd0, 8'd0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 4'h0, 16'h0024, 8'hA5, 1'b1, 8'h00, 5'd0, 8'd0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 4'h0, 16'h0024, 8'hA5, 1'b1, 8'h00, 5'd0, 8'd0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 4'h0, 16'h0024, 8'hA5, 1'b1, 8'h24, 5'd0, 8'd0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 4'h0, 16'h0024, 8'hA5, 1'b1, 8'hA5, 5'd0, 8'd0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 4'h0, 16'h0024, 8'hA5, 1'b0, 8'h00, 5'd0, 8'd0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'h2, 16'h1234, 8'h7E, 1'b0, 8'h00, 5'd1, 8'd0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'h2, 16'h1234, 8'h7E, 1'b1, 8'h5A, 5'd0, 8'd0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 4'h2, 16'h1234, 8'h7E, 1'b1, 8'h02, 5'd0, 8'd0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 4'h2, 16'h1234, 8'h7E, 1'b1, 8'h02, 5'd0, 8'd0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 4'h2, 16'h1234, 8'h7E, 1'b1, 8'h12, 5'd0, 8'd0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 4'h2, 16'h1234, 8'h7E, 1'b1, 8'h12, 5'd0, 8'd0, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 4'h2, 16'h1234, 8'h7E, 1'b1, 8'h34, 5'd0, 8'd0, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 4'h2, 16'h1234, 8'h7E, 1'b1, 8'h34, 5'd0, 8'd0, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 4'h2, 16'h1234, 8'h7E, 1'b1, 8'h7E, 5'd0, 8'd0, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 4'h2, 16'h1234, 8'h7E, 1'b1, 8'h7E, 5'd0, 8'd0, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 4'h2, 16'h1234, 8'h7E, 1'b0, 8'h00, 5'd0, 8'd0, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 1'b1, 4'h9, 16'hBEEF, 8'h11, 1'b0, 8'h00, 5'd0, 8'd0, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 1'b1, 4'h9, 16'hBEEF, 8'h11, 1'b0, 8'h00, 5'd0, 8'd0, 1'b0};

    lpc_reset       = 1'b0;
    capture_en      = 1'b1;
    in_clock_enable = 1'b0;
    in_cyctype_dir  = 4'h0;
    in_addr         = 16'h0000;
    in_data         = 8'h00;
    tx_ready        = 1'b1;

    repeat (3) @(negedge lpc_clock);
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_level", fifo_level, 5'd0);
    chk("rst_ovf", overflow_count, 8'd0);
    chk("rst_busy", busy, 1'b0);
    lpc_reset = 1'b1;

    // Per-cycle vectors: single record, toggled ready, capture disabled
    for (int i = 0; i < 21; i++) begin
      in_clock_enable = vecs[i].ce;
      capture_en      = vecs[i].en;
      tx_ready        = vecs[i].rdy;
      in_cyctype_dir  = vecs[i].cyc;
      in_addr         = vecs[i].addr;
      in_data         = vecs[i].data;
      @(negedge lpc_clock);
      chk($sformatf("vec%0d_valid", i), tx_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_data", i), tx_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_level", i), fifo_level, vecs[i].exp_level);
      chk($sformatf("vec%0d_ovf", i), overflow_count, vecs[i].exp_ovf);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
    end

    // Overflow: one record stalled in the serializer, then 18 captures
    capture_en = 1'b1;
    tx_ready   = 1'b0;
    cap(0);
    chk("ovf_prime_valid", tx_valid, 1'b1);
    chk("ovf_prime_data", tx_data, 8'h5A);
    chk("ovf_prime_level", fifo_level, 5'd0);
    for (int r = 1; r <= 18; r++) cap(r);
    chk("ovf_full_level", fifo_level, 5'd16);
    chk("ovf_full_count", overflow_count, 8'd2);
    chk("ovf_hold_data", tx_data, 8'h5A);

    // Drain record 0; capture on the same edge as its last-byte pop
    tx_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("ovf_r0_b%0d", k), tx_data, exp_byte(0, k));
      if (k == 4) begin
        set_rec(19);
        in_clock_enable = 1'b1;
      end
      @(negedge lpc_clock);
    end
    in_clock_enable = 1'b0;
    chk("popush_level", fifo_level, 5'd15);
    chk("popush_ovf", overflow_count, 8'd3);
    for (int r = 1; r <= 16; r++) chk_record("drain", r);
    chk("drain_end_valid", tx_valid, 1'b0);
    chk("drain_end_level", fifo_level, 5'd0);
    chk("drain_end_busy", busy, 1'b0);
    chk("drain_end_ovf", overflow_count, 8'd3);

    // Level held high for 10 cycles produces exactly one record
    cnt = 0;
    for (int c = 0; c < 22; c++) begin
      in_clock_enable = (c < 10);
      @(negedge lpc_clock);
      if (tx_valid) cnt++;
    end
    chk("held_high_bytes", cnt, 5);
    chk("held_high_level", fifo_level, 5'd0);

    // Reset while the level is high: pending record discarded, no recapture
    set_rec(3);
    in_clock_enable = 1'b1;
    @(negedge lpc_clock);
    chk("pre_rst_level", fifo_level, 5'd1);
    #2 lpc_reset = 1'b0;
    #1;
    chk("async_rst_level", fifo_level, 5'd0);
    chk("async_rst_ovf", overflow_count, 8'd0);
    chk("async_rst_busy", busy, 1'b0);
    @(negedge lpc_clock);
    lpc_reset = 1'b1;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge lpc_clock);
      if (tx_valid || busy) cnt++;
    end
    chk("rst_high_activity", cnt, 0);
    chk("rst_high_level", fifo_level, 5'd0);
    in_clock_enable = 1'b0;
    @(negedge lpc_clock);

    // Reset at byte 3 of a record, then one new capture
    tx_ready = 1'b0;
    cap(5);
    tx_ready = 1'b1;
    repeat (3) @(negedge lpc_clock);
    tx_ready = 1'b0;
    chk("mid_b3_valid", tx_valid, 1'b1);
    chk("mid_b3_data", tx_data, exp_byte(5, 3));
    #2 lpc_reset = 1'b0;
    #1;
    chk("mid_rst_valid", tx_valid, 1'b0);
    chk("mid_rst_data", tx_data, 8'h00);
    chk("mid_rst_busy", busy, 1'b0);
    @(negedge lpc_clock);
    lpc_reset = 1'b1;
    @(negedge lpc_clock);
    chk("post_rst_idle", tx_valid, 1'b0);
    tx_ready = 1'b1;
    cap(7);
    chk_record("post_rst", 7);
    chk("post_rst_end_valid", tx_valid, 1'b0);
    chk("post_rst_end_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
